// File: rtl/vga_sync_decoder_if.sv
// Sync/pixel bus between a VGA timing source and the receive-side decoder.
// The source side drives the pixel strobe and raw syncs; the decoder side
// returns recovered coordinates, measurements and lock status.
interface vga_sync_decoder_if;
  logic       pix_en;
  logic       hs_in;
  logic       vs_in;
  logic [9:0] px_x;
  logic [9:0] px_y;
  logic       px_valid;
  logic [9:0] line_len;
  logic [9:0] frame_lines;
  logic       locked;
  logic       frame_start;
  logic       sync_err;

  modport master (
    output pix_en, hs_in, vs_in,
    input  px_x, px_y, px_valid, line_len, frame_lines, locked, frame_start, sync_err
  );

  modport slave (
    input  pix_en, hs_in, vs_in,
    output px_x, px_y, px_valid, line_len, frame_lines, locked, frame_start, sync_err
  );
endinterface

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing decoder: recovers pixel/line counters from hs/vs,
// measures line length and frame height, tracks lock and reports the active
// window as 0-based pixel coordinates.
module vga_sync_decoder #(
  parameter int HBP = 144,
  parameter int HFP = 784,
  parameter int VBP = 31,
  parameter int VFP = 511
) (
  input logic               mclk,
  input logic               rst_n,
  vga_sync_decoder_if.slave bus
);

  localparam logic [9:0] CNT_MAX = 10'd1023;
  localparam logic [9:0] HBP_C   = 10'(HBP);
  localparam logic [9:0] HFP_C   = 10'(HFP);
  localparam logic [9:0] VBP_C   = 10'(VBP);
  localparam logic [9:0] VFP_C   = 10'(VFP);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    VERIFY  = 2'd2,
    LOCKED  = 2'd3
  } state_t;

  logic       hs_meta_r, hs_sync_r, hs_dly_r;
  logic       vs_meta_r, vs_sync_r, vs_dly_r;
  logic [9:0] hcnt_r, vcnt_r;
  logic       vs_pend_r;
  logic [9:0] line_len_r, frame_lines_r;
  logic       frame_start_r;
  state_t     state_r, state_n;
  logic [9:0] ref_len_r, ref_len_n;
  logic [9:0] ref_lines_r, ref_lines_n;
  logic       ref_vld_r, ref_vld_n;
  logic       err_s;
  logic       locked_r, sync_err_r;
  logic       px_valid_r;
  logic [9:0] px_x_r, px_y_r;

  logic       hs_edge_s, vs_edge_s, frame_evt_s, timeout_s, len_bad_s, win_s;
  logic [9:0] len_meas_s, lines_meas_s;

  // Edge events are only meaningful on pixel strobes; a saturated counter
  // reports 1023 rather than wrapping to 0.
  assign hs_edge_s    = bus.pix_en & hs_sync_r & ~hs_dly_r;
  assign vs_edge_s    = bus.pix_en & vs_sync_r & ~vs_dly_r;
  assign frame_evt_s  = hs_edge_s & (vs_pend_r | vs_edge_s);
  assign len_meas_s   = (hcnt_r == CNT_MAX) ? CNT_MAX : (hcnt_r + 10'd1);
  assign lines_meas_s = (vcnt_r == CNT_MAX) ? CNT_MAX : (vcnt_r + 10'd1);
  assign timeout_s    = (hcnt_r == CNT_MAX) | (vcnt_r == CNT_MAX);
  assign len_bad_s    = hs_edge_s & ref_vld_r & (len_meas_s != ref_len_r);
  assign win_s        = (hcnt_r > HBP_C) & (hcnt_r < HFP_C) & (vcnt_r > VBP_C) & (vcnt_r < VFP_C);

  // Two-flop synchronisers on the asynchronous syncs, plus pix_en-qualified delay flops for edge detection.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      hs_meta_r <= 1'b0; hs_sync_r <= 1'b0; hs_dly_r <= 1'b0;
      vs_meta_r <= 1'b0; vs_sync_r <= 1'b0; vs_dly_r <= 1'b0;
    end else begin
      hs_meta_r <= bus.hs_in;
      hs_sync_r <= hs_meta_r;
      vs_meta_r <= bus.vs_in;
      vs_sync_r <= vs_meta_r;
      if (bus.pix_en) begin
        hs_dly_r <= hs_sync_r;
        vs_dly_r <= vs_sync_r;
      end
    end
  end

  // Pixel/line counters and measurements; a vs edge coinciding with an hs edge makes that line line 0.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_r        <= 10'd0;
      vcnt_r        <= 10'd0;
      vs_pend_r     <= 1'b0;
      line_len_r    <= 10'd0;
      frame_lines_r <= 10'd0;
      frame_start_r <= 1'b0;
    end else begin
      frame_start_r <= frame_evt_s;
      if (bus.pix_en) begin
        if (hs_edge_s) begin
          hcnt_r     <= 10'd0;
          line_len_r <= len_meas_s;
          if (frame_evt_s) begin
            vcnt_r        <= 10'd0;
            frame_lines_r <= lines_meas_s;
            vs_pend_r     <= 1'b0;
          end else if (vcnt_r != CNT_MAX) begin
            vcnt_r <= vcnt_r + 10'd1;
          end
        end else begin
          if (hcnt_r != CNT_MAX) begin
            hcnt_r <= hcnt_r + 10'd1;
          end
          if (vs_edge_s) begin
            vs_pend_r <= 1'b1;
          end
        end
      end
    end
  end

  // Lock FSM state and reference measurements.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= SEARCH;
      ref_len_r   <= 10'd0;
      ref_lines_r <= 10'd0;
      ref_vld_r   <= 1'b0;
      locked_r    <= 1'b0;
      sync_err_r  <= 1'b0;
    end else begin
      state_r     <= state_n;
      ref_len_r   <= ref_len_n;
      ref_lines_r <= ref_lines_n;
      ref_vld_r   <= ref_vld_n;
      locked_r    <= (state_n == LOCKED);
      sync_err_r  <= err_s;
    end
  end

  // Lock FSM next state: every fall-back to SEARCH from a tracking state flags an error.
  always_comb begin
    state_n     = state_r;
    ref_len_n   = ref_len_r;
    ref_lines_n = ref_lines_r;
    ref_vld_n   = ref_vld_r;
    err_s       = 1'b0;
    if (bus.pix_en) begin
      case (state_r)
        SEARCH: begin
          if (frame_evt_s) begin
            state_n   = MEASURE;
            ref_vld_n = 1'b0;
          end else begin
            state_n = SEARCH;
          end
        end
        MEASURE: begin
          if (timeout_s || len_bad_s) begin
            state_n = SEARCH;
            err_s   = 1'b1;
          end else if (frame_evt_s && ref_vld_r) begin
            ref_lines_n = lines_meas_s;
            state_n     = VERIFY;
          end else if (hs_edge_s && !ref_vld_r) begin
            ref_len_n = len_meas_s;
            ref_vld_n = 1'b1;
          end else begin
            state_n = MEASURE;
          end
        end
        VERIFY: begin
          if (timeout_s || len_bad_s) begin
            state_n = SEARCH;
            err_s   = 1'b1;
          end else if (frame_evt_s) begin
            if (lines_meas_s == ref_lines_r) begin
              state_n = LOCKED;
            end else begin
              state_n = SEARCH;
              err_s   = 1'b1;
            end
          end else begin
            state_n = VERIFY;
          end
        end
        LOCKED: begin
          if (timeout_s || len_bad_s || (frame_evt_s && (lines_meas_s != ref_lines_r))) begin
            state_n = SEARCH;
            err_s   = 1'b1;
          end else begin
            state_n = LOCKED;
          end
        end
        default: begin
          state_n = SEARCH;
        end
      endcase
    end else begin
      state_n = state_r;
    end
  end

  // Active-window coordinates, forced to 0 outside the window or when not locked.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      px_valid_r <= 1'b0;
      px_x_r     <= 10'd0;
      px_y_r     <= 10'd0;
    end else begin
      px_valid_r <= locked_r & win_s;
      px_x_r     <= (locked_r & win_s) ? (hcnt_r - HBP_C - 10'd1) : 10'd0;
      px_y_r     <= (locked_r & win_s) ? (vcnt_r - VBP_C - 10'd1) : 10'd0;
    end
  end

  assign bus.px_x        = px_x_r;
  assign bus.px_y        = px_y_r;
  assign bus.px_valid    = px_valid_r;
  assign bus.line_len    = line_len_r;
  assign bus.frame_lines = frame_lines_r;
  assign bus.locked      = locked_r;
  assign bus.frame_start = frame_start_r;
  assign bus.sync_err    = sync_err_r;

endmodule
